// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration controller: command word
// layout, opcodes, FSM state encoding and the duty clamp helper.
package pwm_cfg_pkg;

  // Command word width; the host FIFO delivers one word per read.
  localparam int CMD_W = 32;

  // Opcodes carried in the top nibble of a command word.
  localparam logic [3:0] OP_SET_PERIOD = 4'h1;
  localparam logic [3:0] OP_SET_DUTY   = 4'h2;
  localparam logic [3:0] OP_SET_EN     = 4'h3;
  localparam logic [3:0] OP_COMMIT     = 4'h4;

  // FIFO-read FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;

  // Field map of a command word, MSB first: op, ch, reserved, val.
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  ch;
    logic [7:0]  rsvd;
    logic [15:0] val;
  } cmd_t;

  // A duty above the period saturates at the period (100% duty).
  function automatic logic [15:0] clamp_duty(input logic [15:0] duty,
                                             input logic [15:0] period);
    return (duty > period) ? period : duty;
  endfunction

endpackage

// File: rtl/pwm_cfg_chan.sv
// One PWM channel's configuration slice: shadow registers written by
// commands, active registers seen by the PWM core, and the commit-pending
// flag that moves shadow to active on a period boundary.
module pwm_cfg_chan #(
  parameter int CNT_W = 16
) (
  input  logic             rx_clk,
  input  logic             rst_glbl,
  input  logic             set_period,
  input  logic             set_duty,
  input  logic             set_en,
  input  logic             commit_arm,
  input  logic [CNT_W-1:0] val,
  input  logic             en_val,
  input  logic             period_end,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] duty,
  output logic             en,
  output logic             pend,
  output logic             load_err
);
  import pwm_cfg_pkg::*;

  logic [CNT_W-1:0] shadow_period;
  logic [CNT_W-1:0] shadow_duty;
  logic             shadow_en;
  logic             load;
  logic [CNT_W-1:0] duty_lim;

  // Load decision and clamped duty, both from registered shadow values.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    load     = 1'b0;
    duty_lim = '0;
    // A disabled channel has no boundaries to wait for, so it loads as
    // soon as the commit is armed.
    load     = pend & (period_end | ~en);
    duty_lim = CNT_W'(clamp_duty(16'(shadow_duty), 16'(shadow_period)));
  end

  // A zero period cannot run; the load goes ahead but reports an error.
  assign load_err = load & (shadow_period == '0);

  // Shadow registers: written only by decoded commands.
  always_ff @(posedge rx_clk or posedge rst_glbl) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and the block order cannot create races.
    if (rst_glbl) begin
      shadow_period <= '0;
      shadow_duty   <= '0;
      shadow_en     <= 1'b0;
    end else begin
      if (set_period) shadow_period <= val;
      if (set_duty)   shadow_duty   <= val;
      if (set_en)     shadow_en     <= en_val;
    end
  end

  // Active registers: change only on a load so no period is glitched.
  always_ff @(posedge rx_clk or posedge rst_glbl) begin
    if (rst_glbl) begin
      period <= '0;
      duty   <= '0;
      en     <= 1'b0;
    end else if (load) begin
      period <= shadow_period;
      duty   <= duty_lim;
      en     <= shadow_en & (shadow_period != '0);
    end
  end

  // Pending flag: a new commit wins over the clear from a same-cycle load,
  // so the newest shadow values still reach the next boundary.
  always_ff @(posedge rx_clk or posedge rst_glbl) begin
    if (rst_glbl) pend <= 1'b0;
    else          pend <= commit_arm | (pend & ~load);
  end

endmodule

// File: rtl/pwm_cfg_ctrl.sv
// Command-driven configuration controller for a bank of PWM channels.
// Reads command words from the host FIFO with a three-state FSM, decodes
// them into shadow/commit strobes and hands them to per-channel slices.
module pwm_cfg_ctrl #(
  parameter int CH_NUM         = 4,
  parameter int CNT_W          = 16,
  parameter int FIFO_BUS_WIDTH = 4
) (
  input  logic                      rx_clk,
  input  logic                      rst_glbl,
  input  logic [FIFO_BUS_WIDTH*8-1:0] cmd_data,
  input  logic                      cmd_empty,
  output logic                      cmd_rd_en,
  input  logic [CH_NUM-1:0]         pwm_period_end,
  output logic [CH_NUM*CNT_W-1:0]   pwm_period,
  output logic [CH_NUM*CNT_W-1:0]   pwm_duty,
  output logic [CH_NUM-1:0]         pwm_en,
  output logic [CH_NUM-1:0]         commit_pend,
  output logic                      cmd_err
);
  import pwm_cfg_pkg::*;

  logic [1:0]        state;
  cmd_t              cmd_in;
  logic [3:0]        op_q;
  logic [3:0]        ch_q;
  logic [15:0]       val_q;
  logic [CH_NUM-1:0] ch_hit;
  logic              ch_ok;
  logic [CH_NUM-1:0] set_period;
  logic [CH_NUM-1:0] set_duty;
  logic              set_en;
  logic [CH_NUM-1:0] commit_arm;
  logic              exec_err;
  logic [CH_NUM-1:0] load_err;
  logic              unused_rsvd;

  assign cmd_in = cmd_t'(cmd_data[CMD_W-1:0]);

  // The reserved byte carries no meaning and is deliberately dropped.
  assign unused_rsvd = ^cmd_in.rsvd;

  // Read strobe only from IDLE; held low while reset is asserted so the
  // FIFO is never popped during reset.
  assign cmd_rd_en = (state == ST_IDLE) && !cmd_empty && !rst_glbl;

  // FIFO-read FSM: IDLE -> WAIT (data arriving) -> EXEC (decode) -> IDLE.
  always_ff @(posedge rx_clk or posedge rst_glbl) begin
    if (rst_glbl) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!cmd_empty) state <= ST_WAIT;
        ST_WAIT: state <= ST_EXEC;
        ST_EXEC: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the word the FIFO presents in the cycle after the read strobe.
  always_ff @(posedge rx_clk or posedge rst_glbl) begin
    if (rst_glbl) begin
      op_q  <= '0;
      ch_q  <= '0;
      val_q <= '0;
    end else if (state == ST_WAIT) begin
      op_q  <= cmd_in.op;
      ch_q  <= cmd_in.ch;
      val_q <= cmd_in.val;
    end
  end

  // Decode the captured word into per-channel strobes during EXEC.
  always_comb begin
    ch_hit     = '0;
    ch_ok      = 1'b0;
    set_period = '0;
    set_duty   = '0;
    set_en     = 1'b0;
    commit_arm = '0;
    exec_err   = 1'b0;
    // Full 4-bit compare so an out-of-range channel never aliases.
    for (int i = 0; i < CH_NUM; i++) begin
      ch_hit[i] = (ch_q == 4'(i));
    end
    ch_ok = |ch_hit;
    if (state == ST_EXEC) begin
      case (op_q)
        OP_SET_PERIOD: begin
          if (ch_ok) set_period = ch_hit;
          else       exec_err   = 1'b1;
        end
        OP_SET_DUTY: begin
          if (ch_ok) set_duty = ch_hit;
          else       exec_err = 1'b1;
        end
        OP_SET_EN: set_en     = 1'b1;
        OP_COMMIT: commit_arm = val_q[CH_NUM-1:0];
        default:   exec_err   = 1'b1;
      endcase
    end
  end

  // One configuration slice per channel, packed onto the flat buses.
  for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
    pwm_cfg_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .rx_clk     (rx_clk),
      .rst_glbl   (rst_glbl),
      .set_period (set_period[g]),
      .set_duty   (set_duty[g]),
      .set_en     (set_en),
      .commit_arm (commit_arm[g]),
      .val        (val_q[CNT_W-1:0]),
      .en_val     (val_q[g]),
      .period_end (pwm_period_end[g]),
      .period     (pwm_period[g*CNT_W +: CNT_W]),
      .duty       (pwm_duty[g*CNT_W +: CNT_W]),
      .en         (pwm_en[g]),
      .pend       (commit_pend[g]),
      .load_err   (load_err[g])
    );
  end

  // Rejected commands and zero-period loads share one error pulse.
  assign cmd_err = exec_err | (|load_err);

endmodule
